bcd_conv_sched: RTL and testbench

- Round-robin scheduler that shares one combinational 9-bit binary-to-BCD converter among N_REQ requesters (ALU result, operand A, operand B) in the ALU display path.
- Accepts one request at a time, latches its operand into the converter, and waits a fixed settle time.
- Captures ones/tens/hundreds into output registers and presents them with the requester ID on a valid/ready result port.

---
 rtl/bcd_conv_sched.sv | 140 ++++++++++++++
 tb/tb_bcd_conv_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one 9-bit binary-to-BCD converter among N_REQ requesters.
// Build macro BCD_SELFCHECK_EN adds a sticky err output that checks every captured result.
module bcd_conv_sched #(
    parameter int N_REQ  = 3,
    parameter int ID_W   = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [9*N_REQ-1:0] bin_flat,
    output logic [N_REQ-1:0]   ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_id,
    output logic [3:0]         ones,
    output logic [3:0]         tens,
    output logic [3:0]         hundreds
`ifdef BCD_SELFCHECK_EN
    ,
    output logic               err
`endif
);
    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t           state;
    logic [8:0]       bin_q;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  ptr_nxt;
    logic [8:0]       gnt_bin;
    logic [11:0]      conv_bcd;

    // Shift-and-add-3 conversion; result is {hundreds, tens, ones}.
    function automatic logic [11:0] bin2bcd(input logic [8:0] b);
        logic [20:0] sh;
        sh = {12'd0, b};
        for (int i = 0; i < 9; i++) begin
            if (sh[12:9]  >= 4'd5) sh[12:9]  = sh[12:9]  + 4'd3;
            if (sh[16:13] >= 4'd5) sh[16:13] = sh[16:13] + 4'd3;
            if (sh[20:17] >= 4'd5) sh[20:17] = sh[20:17] + 4'd3;
            sh = sh << 1;
        end
        return sh[20:9];
    endfunction

`ifdef BCD_SELFCHECK_EN
    function automatic logic bcd_ok(input logic [11:0] d, input logic [8:0] b);
        logic [9:0] sum;
        sum = 10'(d[11:8]) * 10'd100 + 10'(d[7:4]) * 10'd10 + 10'(d[3:0]);
        return (d[11:8] <= 4'd9) && (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9) && (sum == {1'b0, b});
    endfunction
`endif

    assign conv_bcd = bin2bcd(bin_q);

    // Two descending passes: the second (lowest index at or after ptr) overrides the wrap-around pick.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_bin   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
                gnt_bin   = bin_flat[9*i +: 9];
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
                gnt_bin   = bin_flat[9*i +: 9];
            end
        end
    end

    assign ptr_nxt = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack       <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            ones      <= '0;
            tens      <= '0;
            hundreds  <= '0;
            bin_q     <= '0;
            id_q      <= '0;
            cnt       <= '0;
            ptr       <= '0;
`ifdef BCD_SELFCHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        bin_q        <= gnt_bin;
                        id_q         <= gnt_idx;
                        ack[gnt_idx] <= 1'b1;
                        ptr          <= ptr_nxt;
                        cnt          <= CNT_W'(SETTLE_EFF - 1);
                        state        <= CONV;
                    end
                end
                CONV: begin
                    if (cnt == '0) begin
                        {hundreds, tens, ones} <= conv_bcd;
                        out_id    <= id_q;
                        out_valid <= 1'b1;
                        state     <= HOLD;
`ifdef BCD_SELFCHECK_EN
                        if (!bcd_ok(conv_bcd, bin_q)) err <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    // Returning to IDLE here means the next grant is at least one edge later.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: vector table, hand-written corner sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_bcd_conv_sched;
    localparam int N_REQ      = 3;
    localparam int ID_W       = 2;
    localparam int SETTLE     = 1;
    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N_REQ-1:0]   req = '0;
    logic [9*N_REQ-1:0] bin_flat = '0;
    logic [N_REQ-1:0]   ack;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [ID_W-1:0]    out_id;
    logic [3:0]         ones, tens, hundreds;
`ifdef BCD_SELFCHECK_EN
    logic               err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         id;
        int         val;
        logic [11:0] exp;
    } vec_t;

    vec_t        vecs [9];
    logic [11:0] rr_exp [3];
    logic [N_REQ-1:0] a;
    int          c, exp_id, last;

    // Random-phase model state
    logic [N_REQ-1:0]   r_req;
    logic [9*N_REQ-1:0] r_bin;
    logic               r_rdy;
    int  m_ptr, pend_id, pend_bin, valid_from, free_from, g;
    bit  pend, exp_valid, exp_valid_prev;
    logic [N_REQ-1:0] exp_ack;

    bcd_conv_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bin_flat  (bin_flat),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds)
`ifdef BCD_SELFCHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int ptr);
        for (int k = 0; k < N_REQ; k++)
            if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        return -1;
    endfunction

    task automatic set_op(input int id, input int v);
        bin_flat[9*id +: 9] = 9'(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; bin_flat = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for a nonzero ack, sampling 1ns after each rising edge; a stays 0 on timeout.
    task automatic wait_ack(input int maxc, output logic [N_REQ-1:0] av, output int cycles);
        av = '0; cycles = 0;
        while (av == '0 && cycles < maxc) begin
            @(posedge clk); #1;
            cycles++;
            av = ack;
        end
    endtask

    task automatic run_single(input int id, input int v, input logic [11:0] exp);
        logic [N_REQ-1:0] av;
        int cy;
        req[id] = 1'b1; set_op(id, v);
        wait_ack(5, av, cy);
        check("single ack", av, 1 << id);
        check("single ack latency", cy, 1);
        @(negedge clk);
        req[id] = 1'b0; set_op(id, 0);
        @(posedge clk); #1;
        check("single ack one-cycle", ack, 0);
        check("single valid", out_valid, 1);
        check("single id", out_id, id);
        check("single digits", {hundreds, tens, ones}, exp);
        @(posedge clk); #1;
        check("single valid drop", out_valid, 0);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{0, 255, 12'h255};
        vecs[1] = '{1,   0, 12'h000};
        vecs[2] = '{1,   9, 12'h009};
        vecs[3] = '{1,  10, 12'h010};
        vecs[4] = '{1,  99, 12'h099};
        vecs[5] = '{1, 100, 12'h100};
        vecs[6] = '{1, 511, 12'h511};
        vecs[7] = '{2, 408, 12'h408};
        vecs[8] = '{2,  37, 12'h037};
        rr_exp[0] = 12'h100; rr_exp[1] = 12'h037; rr_exp[2] = 12'h009;

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("reset ack", ack, 0);
        check("reset valid", out_valid, 0);
        check("reset id", out_id, 0);
        check("reset digits", {hundreds, tens, ones}, 0);
`ifdef BCD_SELFCHECK_EN
        check("reset err", err, 0);
`endif

        // Table-driven single conversions
        do_reset();
        for (int i = 0; i < 9; i++) run_single(vecs[i].id, vecs[i].val, vecs[i].exp);

        // All requesters held: strict round-robin, fixed grant spacing
        do_reset();
        set_op(0, 100); set_op(1, 37); set_op(2, 9);
        req = '1;
        exp_id = 0; last = 0;
        for (int k = 0; k < 6; k++) begin
            wait_ack(10, a, c);
            check("rr grant", a, 1 << exp_id);
            if (k > 0) check("rr spacing", cyc - last, SETTLE_EFF + 2);
            last = cyc;
            @(posedge clk); #1;
            check("rr ack one-cycle", ack, 0);
            check("rr valid", out_valid, 1);
            check("rr id", out_id, exp_id);
            check("rr digits", {hundreds, tens, ones}, rr_exp[exp_id]);
            exp_id = (exp_id + 1) % N_REQ;
        end
        req = '0;

        // Backpressure: result held, pending requester waits for the handshake
        do_reset();
        out_ready = 1'b0;
        req = 3'b001; set_op(0, 408);
        wait_ack(5, a, c);
        check("bp ack0", a, 3'b001);
        req = 3'b010; set_op(1, 77); set_op(0, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp valid held", out_valid, 1);
            check("bp digits held", {hundreds, tens, ones}, 12'h408);
            check("bp id held", out_id, 0);
            check("bp no ack", ack, 0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp handshake valid", out_valid, 0);
        check("bp handshake no ack", ack, 0);
        @(posedge clk); #1;
        check("bp ack1 after handshake", ack, 3'b010);
        req = '0;
        @(posedge clk); #1;
        check("bp second valid", out_valid, 1);
        check("bp second id", out_id, 1);
        check("bp second digits", {hundreds, tens, ones}, 12'h077);
        @(negedge clk);

        // Reset during CONV discards the result and restarts the pointer
        do_reset();
        req = 3'b010; set_op(1, 300);
        wait_ack(5, a, c);
        check("rst ack1", a, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        check("rst async ack", ack, 0);
        check("rst async valid", out_valid, 0);
        check("rst async id", out_id, 0);
        check("rst async digits", {hundreds, tens, ones}, 0);
        req = 3'b101; set_op(0, 42); set_op(2, 7);
        @(posedge clk); #1;
        check("rst no result", out_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        wait_ack(5, a, c);
        check("rst pointer at 0", a, 3'b001);
        req = '0;
        @(posedge clk); #1;
        check("rst post valid", out_valid, 1);
        check("rst post id", out_id, 0);
        check("rst post digits", {hundreds, tens, ones}, 12'h042);
        @(negedge clk);

        // Randomized traffic against the reference model
        do_reset();
        m_ptr = 0; pend = 0; free_from = 0; valid_from = 0; exp_valid_prev = 0;
        pend_id = 0; pend_bin = 0;
        for (int t = 1; t <= 500; t++) begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
            end
            bin_flat  = 27'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            r_req = req; r_bin = bin_flat; r_rdy = out_ready;
            @(posedge clk);
            exp_ack = '0;
            if (pend && exp_valid_prev && r_rdy) begin
                pend = 0;
                free_from = t + 1;
            end else if (!pend && t >= free_from && r_req != '0) begin
                g = rr_pick(r_req, m_ptr);
                exp_ack = 1 << g;
                pend = 1; pend_id = g; pend_bin = int'(r_bin[9*g +: 9]);
                valid_from = t + SETTLE_EFF;
                m_ptr = (g + 1) % N_REQ;
            end
            exp_valid = pend && (t >= valid_from);
            #1;
            check("rand ack", ack, exp_ack);
            check("rand valid", out_valid, exp_valid);
            if (exp_valid) begin
                check("rand id", out_id, pend_id);
                check("rand digits", {hundreds, tens, ones}, ref_bcd(pend_bin));
            end
            req = req & ~ack;
            exp_valid_prev = exp_valid;
        end
        req = '0;

`ifdef BCD_SELFCHECK_EN
        // Corrupted converter output must set the sticky err flag
        do_reset();
        check("selfcheck clean", err, 0);
        force dut.conv_bcd = 12'h124;
        req = 3'b001; set_op(0, 123);
        wait_ack(5, a, c);
        req = '0;
        @(posedge clk); #1;
        check("selfcheck err set", err, 1);
        check("selfcheck valid", out_valid, 1);
        release dut.conv_bcd;
        repeat (3) @(posedge clk); #1;
        check("selfcheck err sticky", err, 1);
        do_reset();
        check("selfcheck err cleared", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
